keypad_seg_io: RTL and testbench

- Board-I/O front end for the CPU peripheral block.
- Scans a 4x4 matrix keypad and returns a debounced 4-bit key code.
- Time-multiplexes six hex digits onto a 6-digit common-anode seven-segment display.
- Runs entirely in the system clock domain, with internal tick dividers setting scan and refresh rates.

---
 rtl/keypad_seg_io_pkg.sv | 40 ++++
 rtl/keypad_seg_io_keypad_scan.sv | 123 ++++++++++++
 rtl/keypad_seg_io.sv | 71 +++++++
 tb/tb_keypad_seg_io.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/keypad_seg_io_pkg.sv
// Shared constants for the keypad / seven-segment board I/O block:
// geometry, segment patterns and the keypad code map.
package keypad_seg_io_pkg;

    localparam int NUM_ROWS   = 4;
    localparam int NUM_COLS   = 4;
    localparam int NUM_DIGITS = 6;

    // Active-low {dp,g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam logic [7:0] SEG_TABLE [0:15] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Key legend of the 4x4 pad: '*' reports E, '#' reports F
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            4'b11_11: code = 4'hD;
            default:  code = 4'h0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_seg_io_keypad_scan.sv
// Keypad column scanner: row synchroniser, per-column dwell counter and a
// two-consecutive-scan debounce that yields the registered key code.
module keypad_scan
    import keypad_seg_io_pkg::*;
#(
    parameter int KP_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] row,
    output logic [NUM_COLS-1:0] col,
    output logic [3:0]          key_val,
    output logic                key_pressed
);

    localparam int KP_W = (KP_DIV > 1) ? $clog2(KP_DIV) : 1;
    localparam logic [KP_W-1:0] KP_LAST = KP_W'(KP_DIV - 1);

    logic [NUM_ROWS-1:0] sync1_r;
    logic [NUM_ROWS-1:0] rs_r;
    logic [KP_W-1:0]     kp_cnt_r;
    logic [1:0]          col_idx_r;
    logic [NUM_COLS-1:0] col_r;
    logic                cand_valid_r;
    logic [3:0]          cand_code_r;
    logic                prev_valid_r;
    logic [3:0]          prev_code_r;
    logic [3:0]          key_val_r;
    logic                key_pressed_r;

    logic                sample_s;
    logic                hit_s;
    logic [1:0]          row_sel_s;
    logic                scan_valid_s;
    logic [3:0]          scan_code_s;

    // Two-flop synchroniser on the pulled-up row lines
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_r <= 4'hF;
            rs_r    <= 4'hF;
        end else begin
            sync1_r <= row;
            rs_r    <= sync1_r;
        end
    end

    // Dwell counter and one-hot-low column rotation
    always_ff @(posedge clk) begin
        if (!rst) begin
            kp_cnt_r  <= '0;
            col_idx_r <= 2'd0;
            col_r     <= 4'b1110;
        end else if (kp_cnt_r == KP_LAST) begin
            kp_cnt_r  <= '0;
            col_idx_r <= col_idx_r + 2'd1;
            col_r     <= {col_r[2:0], col_r[3]};
        end else begin
            kp_cnt_r  <= kp_cnt_r + KP_W'(1);
        end
    end

    // This scan's candidate including the current sample; first hit in scan order wins
    always_comb begin
        sample_s     = (kp_cnt_r == KP_LAST);
        hit_s        = (rs_r != 4'hF);
        row_sel_s    = 2'd3;
        scan_valid_s = cand_valid_r;
        scan_code_s  = cand_code_r;
        if (!rs_r[0]) begin
            row_sel_s = 2'd0;
        end else if (!rs_r[1]) begin
            row_sel_s = 2'd1;
        end else if (!rs_r[2]) begin
            row_sel_s = 2'd2;
        end else begin
            row_sel_s = 2'd3;
        end
        if (!cand_valid_r && hit_s) begin
            scan_valid_s = 1'b1;
            scan_code_s  = key_code(row_sel_s, col_idx_r);
        end else begin
            scan_valid_s = cand_valid_r;
            scan_code_s  = cand_code_r;
        end
    end

    // Debounce: a key registers only when two consecutive full scans agree
    always_ff @(posedge clk) begin
        if (!rst) begin
            cand_valid_r  <= 1'b0;
            cand_code_r   <= 4'h0;
            prev_valid_r  <= 1'b0;
            prev_code_r   <= 4'h0;
            key_val_r     <= 4'h0;
            key_pressed_r <= 1'b0;
        end else if (sample_s && (col_idx_r == 2'd3)) begin
            if (scan_valid_s && prev_valid_r && (prev_code_r == scan_code_s)) begin
                key_val_r     <= scan_code_s;
                key_pressed_r <= 1'b1;
            end else if (!scan_valid_s) begin
                key_pressed_r <= 1'b0;
            end else begin
                key_pressed_r <= key_pressed_r;
            end
            prev_valid_r <= scan_valid_s;
            prev_code_r  <= scan_valid_s ? scan_code_s : 4'h0;
            cand_valid_r <= 1'b0;
            cand_code_r  <= 4'h0;
        end else if (sample_s) begin
            cand_valid_r <= scan_valid_s;
            cand_code_r  <= scan_code_s;
        end else begin
            cand_valid_r <= cand_valid_r;
            cand_code_r  <= cand_code_r;
        end
    end

    assign col         = col_r;
    assign key_val     = key_val_r;
    assign key_pressed = key_pressed_r;

endmodule

// File: rtl/keypad_seg_io.sv
// Board I/O front end: 4x4 keypad scanner plus a six-digit multiplexed
// common-anode seven-segment display driver.
module keypad_seg_io
    import keypad_seg_io_pkg::*;
#(
    parameter int KP_DIV  = 50000,
    parameter int SEG_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_ROWS-1:0]     row,
    output logic [NUM_COLS-1:0]     col,
    output logic [3:0]              key_val,
    output logic                    key_pressed,
    input  logic [NUM_DIGITS-1:0]   enables,
    input  logic [4*NUM_DIGITS-1:0] data,
    output logic [7:0]              seven_segs_point,
    output logic [NUM_DIGITS-1:0]   show_one
);

    localparam int SEG_W = (SEG_DIV > 1) ? $clog2(SEG_DIV) : 1;
    localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(SEG_DIV - 1);

    logic [SEG_W-1:0]        seg_cnt_r;
    logic [2:0]              dig_idx_r;
    logic [3:0]              nib_s;
    logic [7:0]              segs_s;
    logic [NUM_DIGITS-1:0]   show_s;

    keypad_scan #(
        .KP_DIV(KP_DIV)
    ) u_keypad_scan (
        .clk        (clk),
        .rst        (rst),
        .row        (row),
        .col        (col),
        .key_val    (key_val),
        .key_pressed(key_pressed)
    );

    // Digit refresh counter; dig_idx walks 0..5 and wraps
    always_ff @(posedge clk) begin
        if (!rst) begin
            seg_cnt_r <= '0;
            dig_idx_r <= 3'd0;
        end else if (seg_cnt_r == SEG_LAST) begin
            seg_cnt_r <= '0;
            dig_idx_r <= (dig_idx_r == 3'd5) ? 3'd0 : dig_idx_r + 3'd1;
        end else begin
            seg_cnt_r <= seg_cnt_r + SEG_W'(1);
        end
    end

    // Current digit drive; a disabled digit is fully blanked, dp always off
    always_comb begin
        nib_s  = data[{dig_idx_r, 2'b00} +: 4];
        show_s = 6'h3F;
        segs_s = 8'hFF;
        if (enables[dig_idx_r]) begin
            show_s = ~(6'b000001 << dig_idx_r);
            segs_s = SEG_TABLE[nib_s] | 8'h80;
        end else begin
            show_s = 6'h3F;
            segs_s = 8'hFF;
        end
    end

    assign show_one         = show_s;
    assign seven_segs_point = segs_s;

endmodule

// File: tb/tb_keypad_seg_io.sv
// Directed bench for keypad_seg_io: display vector table plus keypad
// debounce sequences driven through a simple matrix keypad model.
module tb_keypad_seg_io;

    logic        clk;
    logic        rst;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_val;
    logic        key_pressed;
    logic [5:0]  enables;
    logic [23:0] data;
    logic [7:0]  seven_segs_point;
    logic [5:0]  show_one;

    int checks;
    int errors;

    logic [3:0] pressed [4];
    logic       ovr;
    logic [3:0] row_force;
    logic [3:0] row_model;

    typedef struct {
        logic [5:0]  en;
        logic [23:0] dat;
        logic [5:0]  show;
        logic [7:0]  segs;
    } disp_vec_t;

    disp_vec_t vecs [12];

    keypad_seg_io #(
        .KP_DIV (4),
        .SEG_DIV(2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .row             (row),
        .col             (col),
        .key_val         (key_val),
        .key_pressed     (key_pressed),
        .enables         (enables),
        .data            (data),
        .seven_segs_point(seven_segs_point),
        .show_one        (show_one)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical keypad: a row reads low when a pressed key sits in a driven column
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_model[r] = ~|(pressed[r] & ~col);
        end
        row = ovr ? row_force : row_model;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_level(input logic lvl, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (key_pressed === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic release_all();
        for (int r = 0; r < 4; r++) pressed[r] = 4'b0000;
    endtask

    initial begin
        logic ok;
        int   seen;
        checks = 0;
        errors = 0;
        ovr = 1'b0;
        row_force = 4'hF;
        release_all();
        rst = 1'b0;
        enables = 6'h3F;
        data = 24'h12AB0F;

        vecs[0]  = '{6'h3F, 24'h12AB0F, 6'b111110, 8'h8E};
        vecs[1]  = '{6'h3F, 24'h12AB0F, 6'b111101, 8'hC0};
        vecs[2]  = '{6'h3F, 24'h12AB0F, 6'b111011, 8'h83};
        vecs[3]  = '{6'h3F, 24'h12AB0F, 6'b110111, 8'h88};
        vecs[4]  = '{6'h3F, 24'h12AB0F, 6'b101111, 8'hA4};
        vecs[5]  = '{6'h3F, 24'h12AB0F, 6'b011111, 8'hF9};
        vecs[6]  = '{6'h01, 24'h12AB0F, 6'b111110, 8'h8E};
        vecs[7]  = '{6'h01, 24'h12AB0F, 6'b111111, 8'hFF};
        vecs[8]  = '{6'h01, 24'h12AB0F, 6'b111111, 8'hFF};
        vecs[9]  = '{6'h01, 24'h12AB0F, 6'b111111, 8'hFF};
        vecs[10] = '{6'h01, 24'h12AB0F, 6'b111111, 8'hFF};
        vecs[11] = '{6'h01, 24'h12AB0F, 6'b111111, 8'hFF};

        repeat (3) @(negedge clk);
        check("rst_col", 32'(col), 32'h0000000E);
        check("rst_key_val", 32'(key_val), 32'h0);
        check("rst_key_pressed", 32'(key_pressed), 32'h0);
        check("rst_show_one", 32'(show_one), 32'h0000003E);

        // Display table: one digit step per SEG_DIV cycles, wrapping after digit 5
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            enables = vecs[i].en;
            data    = vecs[i].dat;
            #1;
            check($sformatf("disp%0d_show", i), 32'(show_one), 32'(vecs[i].show));
            check($sformatf("disp%0d_segs", i), 32'(seven_segs_point), 32'(vecs[i].segs));
            repeat (2) @(negedge clk);
        end

        // Key 7 (row2, col0) held from a fresh scan start
        rst = 1'b0;
        pressed[2] = 4'b0001;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("key7_one_scan_not_enough", 32'(key_pressed), 32'h0);
        wait_level(1'b1, 40, ok);
        check("key7_registered", 32'(ok), 32'h1);
        check("key7_val", 32'(key_val), 32'h7);
        release_all();
        wait_level(1'b0, 40, ok);
        check("key7_release", 32'(ok), 32'h1);
        check("key7_val_held", 32'(key_val), 32'h7);

        // One-dwell glitch on row1 while column 1 is driven
        ovr = 1'b1;
        row_force = 4'hF;
        for (int i = 0; i < 20 && col == 4'b1101; i++) @(negedge clk);
        for (int i = 0; i < 20 && col != 4'b1101; i++) @(negedge clk);
        check("glitch_col_found", 32'(col), 32'h0000000D);
        row_force = 4'b1101;
        repeat (4) @(negedge clk);
        row_force = 4'hF;
        seen = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (key_pressed) seen++;
        end
        check("glitch_no_press", 32'(seen), 32'h0);
        check("glitch_val_kept", 32'(key_val), 32'h7);
        ovr = 1'b0;

        // Key 6 (row1, col2)
        pressed[1] = 4'b0100;
        wait_level(1'b1, 60, ok);
        check("key6_registered", 32'(ok), 32'h1);
        check("key6_val", 32'(key_val), 32'h6);
        release_all();
        wait_level(1'b0, 40, ok);
        check("key6_release", 32'(ok), 32'h1);

        // Simultaneous 2 (row0, col1) and D (row3, col3): lower column wins
        pressed[0] = 4'b0010;
        pressed[3] = 4'b1000;
        wait_level(1'b1, 60, ok);
        check("multi_registered", 32'(ok), 32'h1);
        check("multi_val", 32'(key_val), 32'h2);

        // Reset mid-operation with keys still held
        rst = 1'b0;
        @(negedge clk);
        check("midrst_col", 32'(col), 32'h0000000E);
        check("midrst_key_val", 32'(key_val), 32'h0);
        check("midrst_key_pressed", 32'(key_pressed), 32'h0);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_debounce_restart", 32'(key_pressed), 32'h0);
        wait_level(1'b1, 40, ok);
        check("midrst_reregistered", 32'(ok), 32'h1);
        check("midrst_val", 32'(key_val), 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
